// File: rtl/run_controller.sv
// Rail Rush game-flow controller: run FSM, lives, invulnerability window, speed ramp, score.
// Define RUN_CTRL_SPEED_RAMP_EN to enable the in-run speed ramp; otherwise speed stays at START_SPEED.
module run_controller #(
   parameter int START_LIVES       = 3,
   parameter int START_SPEED       = 4,
   parameter int MAX_SPEED         = 12,
   parameter int RAMP_FRAMES       = 600,
   parameter int HIT_FREEZE_FRAMES = 30,
   parameter int INVULN_FRAMES     = 90,
   parameter int OVER_HOLD_FRAMES  = 120
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        frame_done,
   input  logic        start_btn,
   input  logic        hit,
   output logic        game_active,
   output logic [3:0]  speed,
   output logic [1:0]  lives,
   output logic [15:0] score,
   output logic        invuln_blink,
   output logic        game_over
);
   if (START_LIVES < 1 || START_LIVES > 3 || MAX_SPEED > 15 || START_SPEED > MAX_SPEED ||
       RAMP_FRAMES < 1 || RAMP_FRAMES > 1023 ||
       HIT_FREEZE_FRAMES < 1 || HIT_FREEZE_FRAMES > 255 ||
       INVULN_FRAMES < 1 || INVULN_FRAMES > 255 ||
       OVER_HOLD_FRAMES < 1 || OVER_HOLD_FRAMES > 255) begin : g_bad_param
      $error("run_controller: parameter out of range");
   end

   localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
   localparam logic [3:0] SPEED_INIT = 4'(START_SPEED);
   localparam logic [3:0] SPEED_MAX  = 4'(MAX_SPEED);
   localparam logic [7:0] FREEZE_LEN = 8'(HIT_FREEZE_FRAMES);
   localparam logic [7:0] INVULN_LEN = 8'(INVULN_FRAMES);
   localparam logic [7:0] HOLD_LEN   = 8'(OVER_HOLD_FRAMES);

   typedef enum logic [1:0] {IDLE, RUN, HIT, OVER} state_t;

   state_t      state, state_nx;
   logic [3:0]  speed_nx;
   logic [1:0]  lives_nx;
   logic [15:0] score_nx;
   logic [7:0]  invuln, invuln_nx;
   logic [7:0]  timer, timer_nx;   // freeze countdown in HIT, hold countdown in OVER
   logic        restart;
   logic        blink_nx;
   logic [16:0] score_sum;

`ifdef RUN_CTRL_SPEED_RAMP_EN
   localparam logic [9:0] RAMP_LAST = 10'(RAMP_FRAMES - 1);
   logic [9:0] ramp, ramp_nx;
`endif

   assign score_sum = {1'b0, score} + {13'd0, speed};

   always_comb begin
      state_nx  = state;
      speed_nx  = speed;
      lives_nx  = lives;
      score_nx  = score;
      invuln_nx = invuln;
      timer_nx  = timer;
      restart   = 1'b0;
`ifdef RUN_CTRL_SPEED_RAMP_EN
      ramp_nx   = ramp;
`endif
      case (state)
         IDLE: restart = start_btn;
         RUN: begin
            score_nx = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            if (invuln != 8'd0) invuln_nx = invuln - 8'd1;
`ifdef RUN_CTRL_SPEED_RAMP_EN
            if (ramp == RAMP_LAST) begin
               ramp_nx = 10'd0;
               if (speed < SPEED_MAX) speed_nx = speed + 4'd1;
            end else begin
               ramp_nx = ramp + 10'd1;
            end
`endif
            // Ramp step and score add still apply on the frame of a hit
            if (hit && invuln == 8'd0) begin
               if (lives > 2'd1) begin
                  lives_nx = lives - 2'd1;
                  state_nx = HIT;
                  timer_nx = FREEZE_LEN;
               end else begin
                  lives_nx = 2'd0;
                  state_nx = OVER;
                  timer_nx = HOLD_LEN;
               end
            end
         end
         HIT: begin
            timer_nx = timer - 8'd1;
            if (timer <= 8'd1) begin
               timer_nx  = 8'd0;
               state_nx  = RUN;
               invuln_nx = INVULN_LEN;
            end
         end
         OVER: begin
            if (timer != 8'd0) timer_nx = timer - 8'd1;
            else               restart  = start_btn;
         end
         default: state_nx = IDLE;
      endcase

      if (restart) begin
         state_nx  = RUN;
         lives_nx  = LIVES_INIT;
         speed_nx  = SPEED_INIT;
         score_nx  = 16'd0;
         invuln_nx = 8'd0;
         timer_nx  = 8'd0;
`ifdef RUN_CTRL_SPEED_RAMP_EN
         ramp_nx   = 10'd0;
`endif
      end

      blink_nx = (state_nx == RUN) && (invuln_nx != 8'd0) && invuln_nx[3];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         speed        <= SPEED_INIT;
         lives        <= LIVES_INIT;
         score        <= 16'd0;
         invuln       <= 8'd0;
         timer        <= 8'd0;
         game_active  <= 1'b0;
         invuln_blink <= 1'b0;
         game_over    <= 1'b0;
`ifdef RUN_CTRL_SPEED_RAMP_EN
         ramp         <= 10'd0;
`endif
      end else if (frame_done) begin
         state        <= state_nx;
         speed        <= speed_nx;
         lives        <= lives_nx;
         score        <= score_nx;
         invuln       <= invuln_nx;
         timer        <= timer_nx;
         game_active  <= (state_nx == RUN);
         invuln_blink <= blink_nx;
         game_over    <= (state_nx == OVER);
`ifdef RUN_CTRL_SPEED_RAMP_EN
         ramp         <= ramp_nx;
`endif
      end
   end
endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: directed game scenarios plus random frames,
// compared each frame against a frame-level behavioural model of the game rules.
module tb_run_controller;
   localparam int LIVES0 = 3;
   localparam int SPEED0 = 4;
   localparam int SMAX   = 12;
   localparam int RAMP   = 4;
   localparam int FREEZE = 30;
   localparam int INV    = 90;
   localparam int HOLD   = 120;
`ifdef RUN_CTRL_SPEED_RAMP_EN
   localparam bit RAMP_EN = 1'b1;
`else
   localparam bit RAMP_EN = 1'b0;
`endif

   localparam int M_IDLE = 0, M_RUN = 1, M_HIT = 2, M_OVER = 3;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        frame_done = 1'b0;
   logic        start_btn = 1'b0;
   logic        hit = 1'b0;
   logic        game_active;
   logic [3:0]  speed;
   logic [1:0]  lives;
   logic [15:0] score;
   logic        invuln_blink;
   logic        game_over;

   int checks = 0;
   int failures = 0;
   int frame_no = 0;

   // model state, tracked per frame
   int m_mode, m_lives, m_speed, m_score, m_run_frames, m_inv, m_freeze, m_hold;

   run_controller #(
      .START_LIVES(LIVES0), .START_SPEED(SPEED0), .MAX_SPEED(SMAX), .RAMP_FRAMES(RAMP),
      .HIT_FREEZE_FRAMES(FREEZE), .INVULN_FRAMES(INV), .OVER_HOLD_FRAMES(HOLD)
   ) dut (
      .clock(clock), .reset_n(reset_n), .frame_done(frame_done), .start_btn(start_btn),
      .hit(hit), .game_active(game_active), .speed(speed), .lives(lives), .score(score),
      .invuln_blink(invuln_blink), .game_over(game_over)
   );

   always #5 clock = ~clock;

   function automatic logic [24:0] expected();
      return {(m_mode == M_RUN), 4'(m_speed), 2'(m_lives), 16'(m_score),
              (m_mode == M_RUN && m_inv != 0 && (m_inv & 8) != 0), (m_mode == M_OVER)};
   endfunction

   task automatic check(input string tag);
      logic [24:0] obs, exp;
      obs = {game_active, speed, lives, score, invuln_blink, game_over};
      exp = expected();
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s frame=%0d observed{act,spd,lives,score,blink,over}=%h expected=%h",
                tag, frame_no, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_lives = LIVES0; m_speed = SPEED0; m_score = 0;
      m_run_frames = 0; m_inv = 0; m_freeze = 0; m_hold = 0;
   endtask

   task automatic new_run();
      m_mode = M_RUN; m_lives = LIVES0; m_speed = SPEED0; m_score = 0;
      m_run_frames = 0; m_inv = 0;
   endtask

   task automatic model_frame(input bit h, input bit s);
      case (m_mode)
         M_IDLE: if (s) new_run();
         M_RUN: begin
            m_score = (m_score + m_speed > 65535) ? 65535 : m_score + m_speed;
            if (RAMP_EN) begin
               m_run_frames++;
               if (m_run_frames % RAMP == 0 && m_speed < SMAX) m_speed++;
            end
            if (h && m_inv == 0) begin
               if (m_lives > 1) begin
                  m_lives--; m_mode = M_HIT; m_freeze = FREEZE;
               end else begin
                  m_lives = 0; m_mode = M_OVER; m_hold = HOLD;
               end
            end else if (m_inv > 0) begin
               m_inv--;
            end
         end
         M_HIT: begin
            m_freeze--;
            if (m_freeze == 0) begin m_mode = M_RUN; m_inv = INV; end
         end
         default: begin
            if (m_hold > 0) m_hold--;
            else if (s) new_run();
         end
      endcase
   endtask

   // Idle clocks carry random hit/start noise that must not be sampled.
   task automatic do_frame(input bit h, input bit s, input bit long_hit, input string tag);
      int gap;
      gap = long_hit ? 2 : $urandom_range(1, 2);
      for (int i = 0; i < gap; i++) begin
         frame_done = 1'b0;
         hit        = long_hit ? 1'b1 : 1'($urandom_range(0, 1));
         start_btn  = 1'($urandom_range(0, 1));
         @(posedge clock); #1;
      end
      frame_done = 1'b1; hit = h; start_btn = s;
      @(posedge clock); #1;
      frame_done = 1'b0; hit = 1'b0; start_btn = 1'b0;
      model_frame(h, s);
      frame_no++;
      check(tag);
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      check("reset");
      reset_n = 1'b1;

      do_frame(1'b0, 1'b1, 1'b0, "start");
      repeat (10) do_frame(1'b0, 1'b0, 1'b0, "score_run");
      repeat (40) do_frame(1'b0, 1'b0, 1'b0, "ramp");

      do_frame(1'b1, 1'b0, 1'b1, "hit_multi_clock");
      repeat (FREEZE) do_frame(1'($urandom_range(0, 1)), 1'b0, 1'b0, "freeze");
      repeat (INV) do_frame(1'b1, 1'b0, 1'b0, "invuln_ignore");
      do_frame(1'b1, 1'b0, 1'b0, "hit_after_invuln");
      repeat (FREEZE + INV) do_frame(1'b0, 1'b0, 1'b0, "recover");
      do_frame(1'b1, 1'b0, 1'b0, "fatal_hit");
      repeat (HOLD - 1) do_frame(1'b0, 1'b1, 1'b0, "over_hold_start_ignored");
      repeat (5) do_frame(1'b0, 1'b0, 1'b0, "over_hold_end");
      do_frame(1'b0, 1'b1, 1'b0, "restart");

      for (int i = 0; i < 20000 && m_score != 65535; i++)
         do_frame(1'b0, 1'b0, 1'b0, "sat_climb");
      repeat (5) do_frame(1'b0, 1'b0, 1'b0, "sat_hold");

      repeat (400)
         do_frame(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 1'b0, "random");

      reset_n = 1'b0;
      @(posedge clock); #1;
      model_reset();
      check("reset_sync_point");
      reset_n = 1'b1;
      do_frame(1'b0, 1'b1, 1'b0, "start2");
      do_frame(1'b1, 1'b0, 1'b0, "hit_before_reset");
      repeat (5) do_frame(1'b0, 1'b0, 1'b0, "in_hit");
      #3 reset_n = 1'b0;
      #1 model_reset();
      check("async_reset_mid_hit");
      @(posedge clock); #1;
      check("reset_held");
      reset_n = 1'b1;
      do_frame(1'b0, 1'b0, 1'b0, "idle_after_reset");
      do_frame(1'b0, 1'b1, 1'b0, "start3");
      repeat (3) do_frame(1'b0, 1'b0, 1'b0, "run3");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
